pwm_peripheral: RTL
===================

# pwm_peripheral

Downstream consumer of the SPI register file. Takes the five configuration bytes (output enables, PWM-mode enables, duty cycle) and drives 16 registered output pins. Each pin is forced low, static high, or a shared PWM waveform. The PWM runs from a prescaled 8-bit free-running counter. Duty-cycle updates are double-buffered so a waveform period is never cut short or glitched.

## Interface

Parameters:
- PRESCALE, default 13: clk cycles per PWM counter step. Legal range 1..65535. With a 10 MHz clk, the period is 256*13 clk, about 3.0 kHz.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- en_reg_out_7_0  input  8  output enable, pins 7..0
- en_reg_out_15_8  input  8  output enable, pins 15..8
- en_reg_pwm_7_0  input  8  PWM-mode select, pins 7..0
- en_reg_pwm_15_8  input  8  PWM-mode select, pins 15..8
- pwm_duty_cycle  input  8  requested duty, in units of 1/256 period
- out  output  16  registered pin drive; out[i] maps to enable bit i
- period_start  output  1  one-clk pulse marking the start of each PWM period

## Operation

- Derived buses:
  - en_out = {en_reg_out_15_8, en_reg_out_7_0}
  - en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}
- Prescaler pre_cnt, width ceil(log2(PRESCALE)) with a minimum of 1:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick = (pre_cnt == PRESCALE-1).
  - PRESCALE=1 gives tick every cycle.
- PWM counter pwm_cnt, 8 bits:
  - Increments on tick and wraps 255 to 0.
  - Period = 256*PRESCALE clk.
- Wrap event: tick && pwm_cnt==255.
- Duty shadow duty_act, 8 bits:
  - Loads pwm_duty_cycle only on the wrap edge, so it is stable for a whole period.
  - Changes on pwm_duty_cycle at any other time have no effect until the next wrap.
- PWM level:
  - pwm_lvl = 1 if duty_act==8'hFF.
  - Otherwise pwm_lvl = (pwm_cnt < duty_act), an unsigned 8-bit compare.
  - Duty 0 gives constant low. Duty N in 1..254 gives high for pwm_cnt 0..N-1. Duty 255 gives 100% high, not 255/256.
- Per-pin select, registered each clk into out[i]:
  - en_out[i]==0 gives 0, overriding en_pwm.
  - en_out[i]==1 and en_pwm[i]==0 gives 1.
  - en_out[i]==1 and en_pwm[i]==1 gives pwm_lvl.
- Enable inputs are not shadowed. They are already synchronous to clk and take effect on the next out update.
- period_start is registered: period_start <= wrap event. It is high for exactly the one clk in which pwm_cnt==0 and pre_cnt==0.
- No state machine beyond the two counters. The counters free-run regardless of enables.

## Timing

- Reset (rst_n low, asynchronous) clears:
  - pre_cnt=0, pwm_cnt=0, duty_act=0
  - out=16'h0000, period_start=0
- First PWM period after reset uses duty_act=0, so PWM pins are low until the first wrap. Static-high pins rise 1 clk after reset release.
- Latency:
  - Enable change at edge E appears on out after edge E+1.
  - Duty change applies to the period beginning after the next wrap edge. The first out update for it is 1 clk after period_start rises.
- pwm_lvl transitions occur at tick edges. out follows 1 clk later, so all PWM pins switch in the same cycle with no skew.
- High time on a PWM pin at duty N (0<N<255) is exactly N*PRESCALE clk per 256*PRESCALE-clk period.
- Duty written on the exact wrap edge: the value sampled at that edge is loaded.
- Enable changed on the wrap edge: the new enable combines with the new period's pwm_lvl.
- Reset asserted mid-period: out drops to 0 immediately (asynchronous). Counters restart from 0 on release.

## Test plan

- Reset: hold rst_n low with nonzero inputs -> out=0000, period_start=0. Release with en_out=FFFF, en_pwm=0000 -> out=FFFF after 1 clk, stable thereafter.
- 50% PWM: PRESCALE=13, en_out=0001, en_pwm=0001, duty=0x80 -> out[0] low for the first period. Then per 3328 clk: high 1664, low 1664. period_start pulses every 3328 clk. out[15:1]=0.
- Duty extremes: duty=0x00 -> PWM pins constant 0 across 3 periods. duty=0xFF -> constant 1 across 3 periods. duty=0x01 -> high exactly PRESCALE clk per period.
- Mid-period update: duty=0x40, then write 0xC0 at pwm_cnt=0x10 -> current period high 64 ticks. Next period (after period_start) high 192 ticks. No runt pulse.
- Override and mixing: en_out=00F0, en_pwm=FF30, duty=0x80 -> out[5:4] PWM, out[7:6] static 1, all others 0. Clearing en_out[4] -> out[4]=0 one clk later, mid-pulse.
- Reset mid-operation: assert rst_n during a high phase -> out=0000 asynchronously. After release, first-period PWM pins low, period_start first pulses 256*PRESCALE clk after release.

Source files
------------

// File: rtl/pwm_peripheral.sv
// 16-pin output driver: each pin is low, static high, or a shared PWM level.
// PWM duty is double-buffered so it only changes on a period boundary.
module pwm_peripheral #(
   parameter int PRESCALE = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_cnt;
   logic [7:0]    pwm_cnt;
   logic [7:0]    duty_act;
   logic [15:0]   en_out;
   logic [15:0]   en_pwm;
   logic [15:0]   out_nxt;
   logic          tick;
   logic          wrap;
   logic          pwm_lvl;

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
   assign tick   = (pre_cnt == PRE_MAX);
   assign wrap   = tick && (pwm_cnt == 8'hFF);

   // Duty 255 means fully on rather than 255/256.
   assign pwm_lvl = (duty_act == 8'hFF) || (pwm_cnt < duty_act);
   assign out_nxt = en_out & (~en_pwm | {16{pwm_lvl}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt      <= '0;
         pwm_cnt      <= '0;
         duty_act     <= '0;
         out          <= '0;
         period_start <= 1'b0;
      end else begin
         pre_cnt      <= tick ? '0 : pre_cnt + PW'(1);
         if (tick)
            pwm_cnt   <= pwm_cnt + 8'd1;
         if (wrap)
            duty_act  <= pwm_duty_cycle;
         out          <= out_nxt;
         period_start <= wrap;
      end
   end

endmodule
